// File: rtl/fifo_pkg.sv
// Shared sizing constants and helpers for the synchronous FIFO.
package fifo_pkg;

    localparam int DATA_SIZE_DEF = 8;
    localparam int ADDR_SIZE_DEF = 4;

    function automatic int fifo_depth(input int addr_size);
        return 1 << addr_size;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
module sync_fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [DATA_SIZE-1:0] rdata
);

    logic [DATA_SIZE-1:0] mem [fifo_depth(ADDR_SIZE)];

    // Read returns the old word when the same slot is written this edge.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO: pointers, occupancy, status flags and sticky errors.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int AFULL_TH  = fifo_depth(ADDR_SIZE) - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 err_clr
);

    localparam int DEPTH = fifo_depth(ADDR_SIZE);
    localparam logic [ADDR_SIZE:0] AF = AFULL_TH[ADDR_SIZE:0];
    localparam logic [ADDR_SIZE:0] AE = AEMPTY_TH[ADDR_SIZE:0];

    generate
        if (AFULL_TH < 1 || AFULL_TH > DEPTH - 1) begin : g_bad_af
            $error("sync_fifo: AFULL_TH out of range");
        end
        if (AEMPTY_TH < 1 || AEMPTY_TH > DEPTH - 1) begin : g_bad_ae
            $error("sync_fifo: AEMPTY_TH out of range");
        end
    endgenerate

    logic [ADDR_SIZE:0]   wr_ptr, rd_ptr;
    logic [ADDR_SIZE:0]   wr_ptr_n, rd_ptr_n, count_n;
    logic                 rd_acc, wr_acc;
    logic                 rd_zero;
    logic [DATA_SIZE-1:0] ram_q;

    always_comb begin
        rd_acc   = rd_en && !empty;
        wr_acc   = wr_en && (!full || rd_acc);
        wr_ptr_n = wr_ptr + {{ADDR_SIZE{1'b0}}, wr_acc};
        rd_ptr_n = rd_ptr + {{ADDR_SIZE{1'b0}}, rd_acc};
        count_n  = count;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_n = count + 1'b1;
            2'b01:   count_n = count - 1'b1;
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            rd_valid     <= 1'b0;
            rd_zero      <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_n;
            rd_ptr       <= rd_ptr_n;
            count        <= count_n;
            full         <= (wr_ptr_n[ADDR_SIZE] != rd_ptr_n[ADDR_SIZE]) &&
                            (wr_ptr_n[ADDR_SIZE-1:0] == rd_ptr_n[ADDR_SIZE-1:0]);
            empty        <= (wr_ptr_n == rd_ptr_n);
            almost_full  <= (count_n >= AF);
            almost_empty <= (count_n <= AE);
            rd_valid     <= rd_acc;
            if (rd_acc)
                rd_zero <= 1'b0;
            // A new error in the same cycle as err_clr keeps the flag set.
            if (wr_en && !wr_acc)
                overflow <= 1'b1;
            else if (err_clr)
                overflow <= 1'b0;
            if (rd_en && empty)
                underflow <= 1'b1;
            else if (err_clr)
                underflow <= 1'b0;
        end
    end

    sync_fifo_ram #(
        .DATA_SIZE(DATA_SIZE),
        .ADDR_SIZE(ADDR_SIZE)
    ) u_ram (
        .clk  (clk),
        .we   (wr_acc),
        .waddr(wr_ptr[ADDR_SIZE-1:0]),
        .wdata(wr_data),
        .re   (rd_acc),
        .raddr(rd_ptr[ADDR_SIZE-1:0]),
        .rdata(ram_q)
    );

    // Storage has no reset, so the output reads zero until the first pop.
    assign rd_data = rd_zero ? '0 : ram_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (8x16, AF=14, AE=2).
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid, full, empty, almost_full, almost_empty;
    logic [4:0] count;
    logic       overflow, underflow;

    int checks = 0;
    int errors = 0;

    sync_fifo #(
        .DATA_SIZE(8),
        .ADDR_SIZE(4),
        .AFULL_TH (14),
        .AEMPTY_TH(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_data = base + 8'(i);
            step();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1 ||
            full !== 1'b0 || almost_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: cnt=%0d e=%b ae=%b f=%b af=%b want 0 1 1 0 0",
                     count, empty, almost_empty, full, almost_full);
        end
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00 ||
            overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: rv=%b rd=%h ov=%b un=%b want 0 00 0 0",
                     rd_valid, rd_data, overflow, underflow);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 16; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            step();
            checks++;
            if (count !== 5'(i) || full !== (i == 16) ||
                almost_full !== (i >= 14) || almost_empty !== (i <= 2) ||
                empty !== 1'b0) begin
                errors++;
                $display("FAIL fill_%0d: cnt=%0d f=%b af=%b ae=%b e=%b",
                         i, count, full, almost_full, almost_empty, empty);
            end
        end
        wr_en = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            rd_en = 1'b1;
            step();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(i) ||
                count !== 5'(16 - i)) begin
                errors++;
                $display("FAIL drain_%0d: rv=%b rd=%h cnt=%0d want 1 %h %0d",
                         i, rd_valid, rd_data, count, 8'(i), 16 - i);
            end
        end
        rd_en = 1'b0;
        step();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h10 || empty !== 1'b1 ||
            underflow !== 1'b0) begin
            errors++;
            $display("FAIL drain_end: rv=%b rd=%h e=%b un=%b want 0 10 1 0",
                     rd_valid, rd_data, empty, underflow);
        end
    endtask

    task automatic test_overflow();
        fill(8'h20);
        wr_en   = 1'b1;
        wr_data = 8'hAA;
        step();
        wr_en = 1'b0;
        checks++;
        if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
            errors++;
            $display("FAIL overflow: ov=%b cnt=%0d f=%b want 1 16 1",
                     overflow, count, full);
        end
    endtask

    task automatic test_full_rw();
        wr_en   = 1'b1;
        wr_data = 8'h55;
        rd_en   = 1'b1;
        step();
        wr_en = 1'b0;
        checks++;
        if (count !== 5'd16 || full !== 1'b1 || rd_valid !== 1'b1 ||
            rd_data !== 8'h20) begin
            errors++;
            $display("FAIL full_rw: cnt=%0d f=%b rv=%b rd=%h want 16 1 1 20",
                     count, full, rd_valid, rd_data);
        end
        for (int i = 1; i <= 15; i++) begin
            step();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 8'h20 + 8'(i)) begin
                errors++;
                $display("FAIL full_rw_rd_%0d: rv=%b rd=%h want 1 %h",
                         i, rd_valid, rd_data, 8'h20 + 8'(i));
            end
        end
        step();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h55 || empty !== 1'b1) begin
            errors++;
            $display("FAIL full_rw_last: rv=%b rd=%h e=%b want 1 55 1",
                     rd_valid, rd_data, empty);
        end
    endtask

    task automatic test_err_clr();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: ov=%b want 0", overflow);
        end
        fill(8'h40);
        wr_en   = 1'b1;
        wr_data = 8'hAA;
        err_clr = 1'b1;
        step();
        wr_en   = 1'b0;
        err_clr = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL err_clr_vs_set: ov=%b want 1", overflow);
        end
    endtask

    task automatic test_empty_rw();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'h33;
        rd_en   = 1'b1;
        step();
        wr_en = 1'b0;
        checks++;
        if (underflow !== 1'b1 || rd_valid !== 1'b0 || count !== 5'd1 ||
            empty !== 1'b0) begin
            errors++;
            $display("FAIL empty_rw: un=%b rv=%b cnt=%0d e=%b want 1 0 1 0",
                     underflow, rd_valid, count, empty);
        end
        step();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h33 || count !== 5'd0 ||
            empty !== 1'b1) begin
            errors++;
            $display("FAIL empty_rw_rd: rv=%b rd=%h cnt=%0d e=%b want 1 33 0 1",
                     rd_valid, rd_data, count, empty);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'h60 + 8'(i);
            step();
        end
        wr_data = 8'h99;
        rd_en   = 1'b1;
        err_clr = 1'b0;
        rst     = 1'b1;
        step();
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1 ||
            full !== 1'b0 || almost_full !== 1'b0 || rd_valid !== 1'b0 ||
            rd_data !== 8'h00 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: cnt=%0d e=%b ae=%b f=%b af=%b rv=%b rd=%h ov=%b un=%b",
                     count, empty, almost_empty, full, almost_full,
                     rd_valid, rd_data, overflow, underflow);
        end
        wr_en   = 1'b1;
        wr_data = 8'h77;
        step();
        wr_en = 1'b0;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h77 || empty !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_rd: rv=%b rd=%h e=%b want 1 77 1",
                     rd_valid, rd_data, empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_full_rw();
        test_err_clr();
        test_empty_rw();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
